// File: rtl/risc_control_ws.sv
// Instruction sequencer for the accumulator RISC CPU with memory wait states, sticky HALTED and done pulse.
// Optional single-step control is enabled by defining CTRL_STEP_EN.

package risc_control_ws_pkg;
    typedef enum logic [2:0] {
        HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, AND = 3'd3,
        XOR = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7
    } opcode_t;
endpackage

module risc_control_ws
    import risc_control_ws_pkg::*;
#(
    parameter int WAIT_W = 4
) (
    input  logic              clk,
    input  logic              rst_,
    input  opcode_t           opcode,
    input  logic              zero,
    input  logic [WAIT_W-1:0] wait_cfg,
    input  logic              resume,
`ifdef CTRL_STEP_EN
    input  logic              step_mode,
    input  logic              step,
`endif
    output logic              loadAc,
    output logic              memRd,
    output logic              memWr,
    output logic              incPc,
    output logic              loadPc,
    output logic              loadIr,
    output logic              halt,
    output logic              inst_done,
    output logic              busy
);

    typedef enum logic [3:0] {
        INST_ADDR  = 4'd0, INST_FETCH = 4'd1, INST_LOAD = 4'd2,
        IDLE       = 4'd3, OP_ADDR    = 4'd4, OP_FETCH  = 4'd5,
        ALU_OP     = 4'd6, STORE      = 4'd7, HALTED    = 4'd8
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic [WAIT_W-1:0] lat_q, lat_d;
    logic              aluop_s;
    logic              adv_s;

    assign aluop_s = (opcode == ADD) || (opcode == AND) || (opcode == XOR) || (opcode == LDA);

`ifdef CTRL_STEP_EN
    assign adv_s = !step_mode || step;
`else
    assign adv_s = 1'b1;
`endif

    // State, wait counter and latched wait value registers
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= INST_ADDR;
            cnt_q   <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
        end
    end

    // Next-state logic; the counter stops at the match so it never wraps
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        case (state_q)
            INST_ADDR: begin
                if (adv_s) begin
                    state_d = INST_FETCH;
                    cnt_d   = '0;
                    lat_d   = wait_cfg;
                end else begin
                    state_d = INST_ADDR;
                end
            end
            INST_FETCH: begin
                if (cnt_q == lat_q) state_d = INST_LOAD;
                else                cnt_d   = cnt_q + WAIT_W'(1);
            end
            INST_LOAD: state_d = IDLE;
            IDLE:      state_d = OP_ADDR;
            OP_ADDR: begin
                if (opcode == HLT) begin
                    state_d = HALTED;
                end else begin
                    state_d = OP_FETCH;
                    cnt_d   = '0;
                    lat_d   = aluop_s ? wait_cfg : '0;
                end
            end
            OP_FETCH: begin
                if (cnt_q == lat_q) state_d = ALU_OP;
                else                cnt_d   = cnt_q + WAIT_W'(1);
            end
            ALU_OP: state_d = STORE;
            STORE:  state_d = INST_ADDR;
            HALTED: begin
                if (resume) state_d = INST_ADDR;
                else        state_d = HALTED;
            end
            default: state_d = INST_ADDR;
        endcase
    end

    // Output decode from state, opcode and zero flag
    always_comb begin
        loadAc    = 1'b0;
        memRd     = 1'b0;
        memWr     = 1'b0;
        incPc     = 1'b0;
        loadPc    = 1'b0;
        loadIr    = 1'b0;
        halt      = 1'b0;
        inst_done = 1'b0;
        busy      = 1'b1;
        case (state_q)
            INST_ADDR:  busy = 1'b1;
            INST_FETCH: memRd = 1'b1;
            INST_LOAD, IDLE: begin
                memRd  = 1'b1;
                loadIr = 1'b1;
            end
            OP_ADDR: begin
                incPc = 1'b1;
                halt  = (opcode == HLT);
            end
            OP_FETCH: memRd = aluop_s;
            ALU_OP: begin
                loadAc = aluop_s;
                memRd  = aluop_s;
                incPc  = (opcode == SKZ) && zero;
                loadPc = (opcode == JMP);
            end
            STORE: begin
                loadAc    = aluop_s;
                memRd     = aluop_s;
                incPc     = (opcode == JMP);
                loadPc    = (opcode == JMP);
                memWr     = (opcode == STO);
                inst_done = 1'b1;
            end
            HALTED: begin
                halt = 1'b1;
                busy = 1'b0;
            end
            default: busy = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_risc_control_ws.sv
// Directed scoreboard bench for risc_control_ws: expected per-cycle strobe vectors are queued per instruction.

module tb_risc_control_ws;
    import risc_control_ws_pkg::*;

    logic       clk = 1'b0;
    logic       rst_ = 1'b0;
    opcode_t    opcode = ADD;
    logic       zero = 1'b0;
    logic [3:0] wait_cfg = 4'd0;
    logic       resume = 1'b0;
    logic       loadAc, memRd, memWr, incPc, loadPc, loadIr, halt, inst_done, busy;

    int         vectors = 0;
    int         miscompares = 0;
    string      tag = "reset";
    logic [8:0] exp_q[$];
    logic [8:0] obs_s;

    risc_control_ws #(.WAIT_W(4)) dut (
        .clk(clk), .rst_(rst_), .opcode(opcode), .zero(zero), .wait_cfg(wait_cfg),
        .resume(resume), .loadAc(loadAc), .memRd(memRd), .memWr(memWr), .incPc(incPc),
        .loadPc(loadPc), .loadIr(loadIr), .halt(halt), .inst_done(inst_done), .busy(busy)
    );

    always #5 clk = ~clk;

    assign obs_s = {loadAc, memRd, memWr, incPc, loadPc, loadIr, halt, inst_done, busy};

    // Vector order: loadAc memRd memWr incPc loadPc loadIr halt inst_done busy
    function automatic logic [8:0] v(bit la, bit rd, bit wr, bit ip, bit lp, bit li, bit h, bit d, bit b);
        return {la, rd, wr, ip, lp, li, h, d, b};
    endfunction

    task automatic push_instr(input opcode_t op, input bit z, input int w);
        bit alu;
        alu = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
        exp_q.push_back(v(0,0,0,0,0,0,0,0,1));
        for (int i = 0; i <= w; i++) exp_q.push_back(v(0,1,0,0,0,0,0,0,1));
        exp_q.push_back(v(0,1,0,0,0,1,0,0,1));
        exp_q.push_back(v(0,1,0,0,0,1,0,0,1));
        exp_q.push_back(v(0,0,0,1,0,0,op == HLT,0,1));
        if (op != HLT) begin
            for (int i = 0; i <= (alu ? w : 0); i++) exp_q.push_back(v(0,alu,0,0,0,0,0,0,1));
            exp_q.push_back(v(alu,alu,0,(op == SKZ) && z,op == JMP,0,0,0,1));
            exp_q.push_back(v(alu,alu,op == STO,op == JMP,op == JMP,0,0,1,1));
        end
    endtask

    task automatic check();
        logic [8:0] e;
        e = exp_q.pop_front();
        vectors++;
        assert (obs_s === e) else begin
            miscompares++;
            $error("FAIL %s @%0t observed=%b expected=%b", tag, $time, obs_s, e);
        end
    endtask

    task automatic run(input int ncyc);
        int n;
        n = 0;
        while (exp_q.size() > 0 && (ncyc < 0 || n < ncyc)) begin
            #2;
            check();
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(v(0,0,0,0,0,0,0,0,1));
        #2;
        check();
        rst_ = 1'b1;

        tag = "add_w0";
        opcode = ADD; zero = 1'b0; wait_cfg = 4'd0;
        push_instr(ADD, 0, 0);
        run(-1);

        tag = "lda_w3";
        opcode = LDA; wait_cfg = 4'd3;
        push_instr(LDA, 0, 3);
        run(-1);

        tag = "lda_w3_cfg_change";
        push_instr(LDA, 0, 3);
        run(9);
        wait_cfg = 4'd0;
        run(-1);

        tag = "skz_z1_resume_ignored";
        opcode = SKZ; zero = 1'b1; resume = 1'b1;
        push_instr(SKZ, 1, 0);
        run(-1);
        resume = 1'b0;

        tag = "skz_z0";
        zero = 1'b0;
        push_instr(SKZ, 0, 0);
        run(-1);

        tag = "jmp";
        opcode = JMP; wait_cfg = 4'd2;
        push_instr(JMP, 0, 2);
        run(-1);

        tag = "sto_w5";
        opcode = STO; wait_cfg = 4'd5;
        push_instr(STO, 0, 5);
        run(-1);

        tag = "and_xor";
        opcode = AND; wait_cfg = 4'd1;
        push_instr(AND, 0, 1);
        run(-1);
        opcode = XOR; wait_cfg = 4'd15;
        push_instr(XOR, 0, 15);
        run(-1);

        tag = "hlt";
        opcode = HLT; wait_cfg = 4'd1;
        push_instr(HLT, 0, 1);
        repeat (10) exp_q.push_back(v(0,0,0,0,0,0,1,0,0));
        run(-1);
        tag = "resume";
        resume = 1'b1;
        exp_q.push_back(v(0,0,0,0,0,0,1,0,0));
        run(-1);
        resume = 1'b0;
        opcode = ADD; wait_cfg = 4'd0;
        push_instr(ADD, 0, 0);
        run(-1);

        tag = "async_reset_dwell";
        opcode = LDA; wait_cfg = 4'd7;
        push_instr(LDA, 0, 7);
        run(16);
        #2;
        check();
        rst_ = 1'b0;
        #1;
        exp_q.delete();
        exp_q.push_back(v(0,0,0,0,0,0,0,0,1));
        check();
        @(posedge clk);
        #1;
        rst_ = 1'b1;
        tag = "post_reset_w7";
        opcode = ADD;
        push_instr(ADD, 0, 7);
        run(-1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/risc_control_ws.md
Name: risc_control_ws

Overview:
- Next-generation instruction sequencer for the accumulator RISC CPU. Drives the accumulator, memory, PC and IR load/increment strobes from the current opcode and the accumulator zero flag.
- Extends the fixed 8-phase sequencer with:
  - a programmable memory wait-state counter on read phases;
  - a sticky HALTED state with a resume handshake;
  - a per-instruction done pulse.
- Sits between the IR/accumulator datapath and the memory/PC blocks.

Parameters:
- WAIT_W, 4, width of the wait-state configuration and counter; 0..2**WAIT_W-1 extra cycles per memory read phase.

Ports:
- clk  input  1  system clock
- rst_  input  1  asynchronous, active-low reset
- opcode  input  opcodeT (3)  current IR opcode: HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP
- zero  input  1  accumulator zero flag
- wait_cfg  input  WAIT_W  extra wait cycles per memory read phase
- resume  input  1  single-cycle request to leave HALTED
- loadAc  output  1  load accumulator
- memRd  output  1  memory read enable
- memWr  output  1  memory write enable
- incPc  output  1  increment PC
- loadPc  output  1  load PC from IR address
- loadIr  output  1  load instruction register
- halt  output  1  CPU halted indicator
- inst_done  output  1  one-cycle pulse on the last phase of every instruction
- busy  output  1  high in every state except HALTED

Behaviour:
- Single clock domain. Reset is asynchronous, active-low (rst_). Reset forces the state to INST_ADDR, the wait counter to 0 and the latched wait value to 0.
- Reset output values: all strobes 0, halt 0, inst_done 0, busy 1.
- States, in order: INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE, HALTED.
- aluop = opcode in {ADD, AND, XOR, LDA}.
- Outputs are decoded combinationally from state, opcode and zero. Default is all 0.
  - INST_ADDR: none.
  - INST_FETCH: memRd.
  - INST_LOAD: memRd, loadIr.
  - IDLE: memRd, loadIr.
  - OP_ADDR: incPc. halt = (opcode==HLT).
  - OP_FETCH: memRd = aluop.
  - ALU_OP: loadAc = aluop; memRd = aluop; incPc = (opcode==SKZ && zero); loadPc = (opcode==JMP).
  - STORE: loadAc = aluop; memRd = aluop; incPc = (opcode==JMP); loadPc = (opcode==JMP); memWr = (opcode==STO); inst_done = 1.
  - HALTED: halt = 1; busy = 0; all strobes 0.
- Transitions:
  - Sequential through the order above; STORE returns to INST_ADDR.
  - OP_ADDR with opcode==HLT goes to HALTED, not OP_FETCH.
  - HALTED holds until resume==1, then goes to INST_ADDR on the next edge.
  - resume is ignored in every other state.
- Wait states:
  - Entering INST_FETCH, and entering OP_FETCH with aluop=1, latches wait_cfg into wait_lat and clears the counter.
  - The FSM stays in that state while count != wait_lat; count increments by 1 per cycle. It advances when count == wait_lat.
  - Outputs are held constant for the whole dwell.
  - wait_cfg changes during a dwell have no effect.
  - OP_FETCH with aluop=0 never waits.
- Latency: instruction = 8 + 2*wait_cfg cycles for aluop opcodes; 8 + wait_cfg for the others (INST_FETCH dwell only). HLT enters HALTED 5 + wait_cfg cycles after INST_ADDR.
- wait_cfg = 2**WAIT_W-1 is legal. The counter never wraps, because it stops at the match.
- Reset asserted mid-dwell or in HALTED immediately returns to INST_ADDR with the counter cleared.
- The opcode must be stable from OP_ADDR through STORE. No internal opcode latch.

Optional Feature:
- Macro CTRL_STEP_EN adds inputs step_mode (1) and step (1).
- Defined:
  - With step_mode=1, INST_ADDR holds until step==1, then advances one instruction; INST_ADDR is re-entered after STORE and waits again.
  - step_mode=0 behaves as without the macro.
  - step has no effect in other states.
- Undefined: the ports are absent and INST_ADDR always advances after one cycle.

Test Plan:
- Reset release, wait_cfg=0, opcode=ADD, zero=0 -> 8-cycle loop. memRd in INST_FETCH..IDLE and OP_FETCH..STORE; loadAc in ALU_OP and STORE; inst_done only in STORE.
- wait_cfg=3, opcode=LDA -> INST_FETCH held 4 cycles and OP_FETCH held 4 cycles, memRd steady; instruction takes 14 cycles. wait_cfg changed to 0 mid-dwell -> dwell still 4.
- opcode=SKZ with zero=1 -> incPc in OP_ADDR and ALU_OP. With zero=0 -> incPc only in OP_ADDR. opcode=JMP -> loadPc in ALU_OP and STORE; incPc in STORE.
- opcode=STO -> memWr=1 only in STORE; OP_FETCH has no dwell even with wait_cfg=5.
- opcode=HLT -> halt=1 in OP_ADDR, then HALTED with halt=1, busy=0 for 10 cycles. resume pulse -> INST_ADDR next cycle, halt=0.
- rst_ low asynchronously during OP_FETCH dwell (wait_cfg=7, count=4) -> outputs 0 at once. After release, INST_FETCH dwells the full 7 extra cycles.
